// File: rtl/display_pkg.sv
// display_pkg: shared display-path defaults and channel indices
package display_pkg;
  localparam int CHAN_W_DEF = 8;
  localparam int WORD_W_DEF = 32;
  localparam int RED = 0;
  localparam int GREEN = 1;
  localparam int BLUE = 2;
endpackage

// File: rtl/pixel_packer.sv
// pixel_packer: gathers serial channels into one zero-padded pixel word
module pixel_packer import display_pkg::*; #(
  parameter int CHAN_W = CHAN_W_DEF,
  parameter int NUM_CHAN = 3,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              strobe,
  input  logic [CHAN_W-1:0] din,
  output logic              pix_valid,
  output logic [WORD_W-1:0] pix_word
);
  logic [1:0] cnt;
  logic [CHAN_W-1:0] hold [4];
  logic [NUM_CHAN*CHAN_W-1:0] used;
  logic last;
  assign last = cnt == 2'(NUM_CHAN-1);
  assign pix_valid = reset_n && !clear && strobe && last;
  assign pix_word = WORD_W'(used);
  // ch0 lands in the most-significant used slot; the live channel is always the LSB slot
  always_comb begin
    used = '0;
    for (int i = 0; i < NUM_CHAN; i++)
      used[(NUM_CHAN-1-i)*CHAN_W +: CHAN_W] = (i == NUM_CHAN-1) ? din : hold[2'(i)];
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
      hold <= '{default: '0};
    end else if (clear) begin
      cnt <= '0;
    end else if (strobe) begin
      if (last) cnt <= '0;
      else begin
        hold[cnt] <= din;
        cnt <= cnt + 2'd1;
      end
    end
  end
endmodule

// File: rtl/pixel_frame_buffer.sv
// pixel_frame_buffer: captures packed pixels into a frame RAM with wrap/stop status and a registered read port
module pixel_frame_buffer import display_pkg::*; #(
  parameter int CHAN_W = CHAN_W_DEF,
  parameter int NUM_CHAN = 3,
  parameter int WORD_W = WORD_W_DEF,
  parameter int DEPTH = 200,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              CSDisplay,
  input  logic [CHAN_W-1:0] FrameIn,
  input  logic              frame_start,
  input  logic              mode_wrap,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              frame_done,
  output logic              full,
  output logic              overflow
);
  logic pix_valid;
  logic [WORD_W-1:0] pix_word;
  logic [WORD_W-1:0] mem [DEPTH];
  logic wr, at_end, rd_ok;
  pixel_packer #(.CHAN_W(CHAN_W), .NUM_CHAN(NUM_CHAN), .WORD_W(WORD_W)) u_packer (
    .clock(clock),
    .reset_n(reset_n),
    .clear(frame_start),
    .strobe(CSDisplay),
    .din(FrameIn),
    .pix_valid(pix_valid),
    .pix_word(pix_word)
  );
  assign wr = pix_valid && !full;
  assign at_end = wr_ptr == ADDR_W'(DEPTH-1);
  assign rd_ok = {1'b0, rd_addr} < (ADDR_W+1)'(DEPTH);
  always_ff @(posedge clock) begin
    if (wr) mem[wr_ptr] <= pix_word;
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      frame_done <= 1'b0;
      full <= 1'b0;
      overflow <= 1'b0;
    end else begin
      frame_done <= wr && at_end;
      if (frame_start) begin
        wr_ptr <= '0;
        full <= 1'b0;
        overflow <= 1'b0;
      end else if (pix_valid) begin
        if (full) overflow <= 1'b1;
        else if (at_end) begin
          if (mode_wrap) wr_ptr <= '0;
          else full <= 1'b1;
        end else wr_ptr <= wr_ptr + 1'b1;
      end
    end
  end
  // nonblocking read of mem gives old data when the same address is written this edge
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_ok ? mem[rd_addr] : '0;
    end
  end
endmodule

// File: tb/tb_pixel_frame_buffer.sv
// tb_pixel_frame_buffer: directed stimulus with a read-data scoreboard and direct status checks
module tb_pixel_frame_buffer;
  logic clock = 0;
  logic reset_n, CSDisplay, frame_start, mode_wrap, rd_en;
  logic [7:0] FrameIn, rd_addr, wr_ptr;
  logic [31:0] rd_data;
  logic rd_valid, frame_done, full, overflow;
  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  logic [31:0] exp_q [$];
  always #5 clock = ~clock;
  pixel_frame_buffer #(.CHAN_W(8), .NUM_CHAN(3), .WORD_W(32), .DEPTH(4), .ADDR_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .CSDisplay(CSDisplay), .FrameIn(FrameIn),
    .frame_start(frame_start), .mode_wrap(mode_wrap), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_ptr(wr_ptr), .frame_done(frame_done),
    .full(full), .overflow(overflow)
  );
  always @(negedge clock) begin
    if (frame_done) done_cnt++;
    if (rd_valid) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL rd_unexpected: rd_valid with no pending read, rd_data=%h", rd_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          mismatched++;
          $display("FAIL rd_data: got %h expected %h", rd_data, e);
        end
      end
    end
  end
  function automatic logic [31:0] pw(input logic [7:0] a, b, c);
    return {8'h00, a, b, c};
  endfunction
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic strobe(input logic [7:0] d);
    CSDisplay = 1; FrameIn = d;
    step();
    CSDisplay = 0;
  endtask
  task automatic pix(input logic [7:0] a, b, c);
    strobe(a); strobe(b); strobe(c);
  endtask
  task automatic rd(input logic [7:0] a, input logic [31:0] e);
    rd_en = 1; rd_addr = a; exp_q.push_back(e);
    step();
    rd_en = 0;
  endtask
  task automatic fstart();
    frame_start = 1;
    step();
    frame_start = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    reset_n = 0; CSDisplay = 0; FrameIn = 0; frame_start = 0; mode_wrap = 0; rd_en = 0; rd_addr = 0;
    step(); step();
    chk("rst_wr_ptr", 32'(wr_ptr), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    reset_n = 1;
    pix(8'h11, 8'h22, 8'h33);
    chk("t1_wr_ptr", 32'(wr_ptr), 1);
    rd(0, 32'h00112233);
    fstart();
    chk("t2_fs_wr_ptr", 32'(wr_ptr), 0);
    strobe(8'hAA); strobe(8'hBB);
    repeat (5) step();
    strobe(8'hCC);
    chk("t2_wr_ptr", 32'(wr_ptr), 1);
    rd(0, 32'h00AABBCC);
    fstart();
    done_cnt = 0;
    for (int k = 1; k <= 4; k++) pix(8'(8'h10 + k), 8'(8'h20 + k), 8'(8'h30 + k));
    chk("t3_frame_done", 32'(frame_done), 1);
    chk("t3_full", 32'(full), 1);
    chk("t3_wr_ptr_full", 32'(wr_ptr), 3);
    chk("t3_no_ovf_yet", 32'(overflow), 0);
    pix(8'h15, 8'h25, 8'h35);
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_wr_ptr_held", 32'(wr_ptr), 3);
    chk("t3_done_once", done_cnt, 1);
    for (int k = 0; k < 4; k++) rd(8'(k), pw(8'(8'h11 + k), 8'(8'h21 + k), 8'(8'h31 + k)));
    rd(5, 32'h0);
    mode_wrap = 1;
    fstart();
    chk("t4_fs_full", 32'(full), 0);
    chk("t4_fs_overflow", 32'(overflow), 0);
    done_cnt = 0;
    for (int k = 1; k <= 6; k++) pix(8'(8'h40 + k), 8'(8'h50 + k), 8'(8'h60 + k));
    step();
    chk("t4_wr_ptr", 32'(wr_ptr), 2);
    chk("t4_done_once", done_cnt, 1);
    chk("t4_full", 32'(full), 0);
    chk("t4_overflow", 32'(overflow), 0);
    rd(0, pw(8'h45, 8'h55, 8'h65));
    rd(1, pw(8'h46, 8'h56, 8'h66));
    rd(2, pw(8'h43, 8'h53, 8'h63));
    mode_wrap = 0;
    fstart();
    strobe(8'h77); strobe(8'h88);
    CSDisplay = 1; FrameIn = 8'h99; frame_start = 1;
    step();
    CSDisplay = 0; frame_start = 0;
    chk("t5_fs_wr_ptr", 32'(wr_ptr), 0);
    pix(8'hA1, 8'hA2, 8'hA3);
    chk("t5_wr_ptr", 32'(wr_ptr), 1);
    rd(0, 32'h00A1A2A3);
    strobe(8'hB1); strobe(8'hB2);
    rd_en = 1; rd_addr = 1; exp_q.push_back(pw(8'h46, 8'h56, 8'h66));
    CSDisplay = 1; FrameIn = 8'hB3;
    step();
    CSDisplay = 0; rd_en = 0;
    rd(1, 32'h00B1B2B3);
    strobe(8'hC1);
    reset_n = 0;
    step();
    chk("t6_rst_wr_ptr", 32'(wr_ptr), 0);
    chk("t6_rst_rd_valid", 32'(rd_valid), 0);
    chk("t6_rst_rd_data", rd_data, 0);
    chk("t6_rst_full", 32'(full), 0);
    chk("t6_rst_overflow", 32'(overflow), 0);
    chk("t6_rst_frame_done", 32'(frame_done), 0);
    reset_n = 1;
    pix(8'hD1, 8'hD2, 8'hD3);
    chk("t6_wr_ptr", 32'(wr_ptr), 1);
    rd(0, 32'h00D1D2D3);
    repeat (3) step();
    chk("pending_reads", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
